supply_ramp_driver: RTL



---
 rtl/rnm_src_pkg.sv | 16 +
 rtl/code_to_real_dac.sv | 14 +
 rtl/supply_ramp_driver.sv | 114 +++++++++++
 3 files changed

// File: rtl/rnm_src_pkg.sv
// Shared types and helpers for the real-number-model stimulus sources.
// Converts integer DAC codes to volts and defines the ramp sequencer states.
package rnm_src_pkg;

   typedef enum logic [1:0] {IDLE, RAMP, DWELL} ramp_state_t;

   // Full-scale code (2**width-1) maps to vfs volts.
   function automatic real code_to_volts(input longint unsigned code,
                                         input real vfs,
                                         input int width);
      longint unsigned full;
      full = (64'd1 << width) - 64'd1;
      return real'(code) * vfs / real'(full);
   endfunction

endpackage

// File: rtl/code_to_real_dac.sv
// Ideal combinational DAC: integer code in, real-valued voltage out.
module code_to_real_dac
   import rnm_src_pkg::*;
#(
   parameter int  CODE_W = 16,
   parameter real VFS    = 1.0
) (
   input  logic [CODE_W-1:0] code,
   output real               vout
);

   assign vout = code_to_volts(64'(code), VFS, CODE_W);

endmodule

// File: rtl/supply_ramp_driver.sv
// Ramp sequencer for the RC bench supply: steps a DAC code toward a commanded
// target, dwells there, pulses done, and exposes the code as a real voltage.
module supply_ramp_driver
   import rnm_src_pkg::*;
#(
   parameter int  CODE_W     = 16,
   parameter int  DWELL_W    = 16,
   parameter real VFS        = 1.0,
   parameter int  RESET_CODE = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [CODE_W-1:0]  cmd_target,
   input  logic [CODE_W-1:0]  cmd_step,
   input  logic [DWELL_W-1:0] cmd_dwell,
   input  logic               abort,
   output logic [CODE_W-1:0]  code,
   output real                vout,
   output logic               busy,
   output logic               done
);

   ramp_state_t        state;
   logic [CODE_W-1:0]  target_q;
   logic [CODE_W-1:0]  step_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] dwell_cnt;
   logic [CODE_W:0]    diff;
   logic               snap;

   assign cmd_ready = (state == IDLE);

   // One extra bit keeps the distance exact across the full code range.
   always_comb begin
      diff = '0;
      if (code > target_q) diff = {1'b0, code} - {1'b0, target_q};
      else                 diff = {1'b0, target_q} - {1'b0, code};
   end

   // Landing on the target instead of stepping guarantees no overshoot or wrap.
   assign snap = (step_q == '0) || (diff <= {1'b0, step_q});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         code      <= CODE_W'(RESET_CODE);
         target_q  <= '0;
         step_q    <= '0;
         dwell_q   <= '0;
         dwell_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  target_q <= cmd_target;
                  step_q   <= cmd_step;
                  dwell_q  <= cmd_dwell;
                  busy     <= 1'b1;
                  if (cmd_target == code) begin
                     state     <= DWELL;
                     dwell_cnt <= cmd_dwell;
                  end else begin
                     state <= RAMP;
                  end
               end
            end
            RAMP: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (snap) begin
                  code      <= target_q;
                  state     <= DWELL;
                  dwell_cnt <= dwell_q;
               end else if (target_q > code) begin
                  code <= code + step_q;
               end else begin
                  code <= code - step_q;
               end
            end
            DWELL: begin
               // The done cycle is still spent in DWELL so a new command
               // cannot be taken while done is visible.
               if (abort || done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (dwell_cnt == '0) begin
                  done <= 1'b1;
               end else begin
                  dwell_cnt <= dwell_cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   code_to_real_dac #(
      .CODE_W (CODE_W),
      .VFS    (VFS)
   ) u_dac (
      .code (code),
      .vout (vout)
   );

endmodule
